ahb_rr_arbiter: RTL and testbench

//  - Parametrised AHB bus arbiter and address/write-data mux for NUM_MASTERS masters sharing one slave bus.
//  - Generalises the fixed two-master HBUSREQ/HGRANT pairing (core 0 / core 1) in mipsfpga_sys.
//  - Adds round-robin fairness, fixed-length-burst protection, locked-transfer hold and a default master.
//  - Sits between the per-core AHB master ports and the shared memory/IO slave decoder.

---
 rtl/ahb_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter with burst/lock protection, address-phase mux and data-phase mux.
// Define AHB_ARB_TIMEOUT_EN to bound bus ownership to MAX_TENURE cycles of contention.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 64
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [NUM_MASTERS-1:0]         HBUSREQ,
    input  logic [NUM_MASTERS-1:0]         HLOCK,
    input  logic [2*NUM_MASTERS-1:0]       HTRANS_M,
    input  logic [3*NUM_MASTERS-1:0]       HBURST_M,
    input  logic [32*NUM_MASTERS-1:0]      HADDR_M,
    input  logic [NUM_MASTERS-1:0]         HWRITE_M,
    input  logic [3*NUM_MASTERS-1:0]       HSIZE_M,
    input  logic [32*NUM_MASTERS-1:0]      HWDATA_M,
    input  logic                           HREADY,
    output logic [NUM_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
    output logic                           HMASTLOCK,
    output logic [1:0]                     HTRANS,
    output logic [2:0]                     HBURST,
    output logic [31:0]                    HADDR,
    output logic                           HWRITE,
    output logic [2:0]                     HSIZE,
    output logic [31:0]                    HWDATA
);
    localparam int N  = NUM_MASTERS;
    localparam int MW = $clog2(NUM_MASTERS);

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [N-1:0]  DEF_OH  = N'(1) << DEFAULT_MASTER;

    localparam logic [1:0] TR_BUSY    = 2'b01;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [2:0] BURST_INCR = 3'b001;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || DEFAULT_MASTER < 0 ||
        DEFAULT_MASTER >= NUM_MASTERS || MAX_TENURE < 1) begin : g_bad_params
        $error("ahb_rr_arbiter: illegal parameter combination");
    end

    function automatic logic [3:0] burst_len(input logic [1:0] kind);
        case (kind)
            2'b01:   burst_len = 4'd3;
            2'b10:   burst_len = 4'd7;
            2'b11:   burst_len = 4'd15;
            default: burst_len = 4'd0;
        endcase
    endfunction

    logic [N-1:0]  grant_q, grant_d;
    logic [MW-1:0] grant_idx_q, grant_idx_d;
    logic [MW-1:0] hmaster_q, hmaster_d;
    logic [MW-1:0] hmaster_data_q, hmaster_data_d;
    logic          mastlock_q, mastlock_d;
    logic [3:0]    burst_rem_q, burst_rem_d;

    logic [1:0]    bus_trans;
    logic [2:0]    bus_burst;
    logic [N-1:0]  req_eff;
    logic          timeout;
    logic          fixed_start, incr_hold, boundary, lock_hold, arb_ok;
    logic [MW-1:0] next_idx;
    logic          found;

    always_comb begin
        bus_trans = '0;
        bus_burst = '0;
        HADDR     = '0;
        HWRITE    = 1'b0;
        HSIZE     = '0;
        HWDATA    = '0;
        for (int i = 0; i < N; i++) begin
            if (hmaster_q == MW'(i)) begin
                bus_trans = HTRANS_M[2*i +: 2];
                bus_burst = HBURST_M[3*i +: 3];
                HADDR     = HADDR_M[32*i +: 32];
                HWRITE    = HWRITE_M[i];
                HSIZE     = HSIZE_M[3*i +: 3];
            end
            if (hmaster_data_q == MW'(i)) begin
                HWDATA = HWDATA_M[32*i +: 32];
            end
        end
    end

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(MAX_TENURE + 1);
    logic [TW-1:0] tenure_q, tenure_d;

    assign timeout = (tenure_q >= TW'(MAX_TENURE)) && !HLOCK[grant_idx_q];

    always_comb begin
        tenure_d = tenure_q;
        if (grant_d != grant_q) begin
            tenure_d = '0;
        end else if (((HBUSREQ & ~grant_q) != '0) && (tenure_q < TW'(MAX_TENURE))) begin
            tenure_d = tenure_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) tenure_q <= '0;
        else        tenure_q <= tenure_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // An owner that has run out of tenure competes as if it were not requesting.
    assign req_eff     = HBUSREQ & ~(timeout ? grant_q : '0);
    assign fixed_start = (bus_trans == TR_NONSEQ) && (bus_burst[2:1] != 2'b00);
    assign incr_hold   = (bus_trans != 2'b00) && (bus_burst == BURST_INCR) && req_eff[grant_idx_q];
    assign boundary    = ((burst_rem_q == 4'd0) && !fixed_start && !incr_hold) ||
                         ((burst_rem_q == 4'd1) && (bus_trans == TR_SEQ));
    assign lock_hold   = HLOCK[grant_idx_q] & HBUSREQ[grant_idx_q];
    assign arb_ok      = HREADY & ~lock_hold & boundary;

    always_comb begin
        next_idx = DEF_IDX;
        found    = 1'b0;
        for (int off = 1; off <= N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req_eff[j] &&
                    ((int'(grant_idx_q) + off == j) || (int'(grant_idx_q) + off == j + N))) begin
                    found    = 1'b1;
                    next_idx = MW'(j);
                end
            end
        end
    end

    always_comb begin
        grant_d        = grant_q;
        grant_idx_d    = grant_idx_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        mastlock_d     = mastlock_q;
        burst_rem_d    = burst_rem_q;
        if (arb_ok) begin
            grant_idx_d = next_idx;
            grant_d     = N'(1) << next_idx;
        end
        if (HREADY) begin
            hmaster_d      = grant_idx_q;
            mastlock_d     = HLOCK[grant_idx_q];
            hmaster_data_d = hmaster_q;
            case (bus_trans)
                TR_NONSEQ: burst_rem_d = burst_len(bus_burst[2:1]);
                TR_SEQ:    burst_rem_d = (burst_rem_q != 4'd0) ? burst_rem_q - 4'd1 : 4'd0;
                TR_BUSY:   burst_rem_d = burst_rem_q;
                default:   burst_rem_d = 4'd0;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q        <= DEF_OH;
            grant_idx_q    <= DEF_IDX;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            mastlock_q     <= 1'b0;
            burst_rem_q    <= 4'd0;
        end else begin
            grant_q        <= grant_d;
            grant_idx_q    <= grant_idx_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            mastlock_q     <= mastlock_d;
            burst_rem_q    <= burst_rem_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = mastlock_q;
    assign HTRANS    = bus_trans;
    assign HBURST    = bus_burst;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter with two masters and MAX_TENURE=8.
module tb_ahb_rr_arbiter;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;

    logic        HCLK, HRESET, HREADY;
    logic [1:0]  HBUSREQ, HLOCK, HWRITE_M;
    logic [3:0]  HTRANS_M;
    logic [5:0]  HBURST_M, HSIZE_M;
    logic [63:0] HADDR_M, HWDATA_M;
    logic [1:0]  HGRANT;
    logic [0:0]  HMASTER;
    logic        HMASTLOCK, HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic [31:0] HADDR, HWDATA;

    int errors = 0;
    int checks = 0;

    ahb_rr_arbiter #(.NUM_MASTERS(2), .DEFAULT_MASTER(0), .MAX_TENURE(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS_M(HTRANS_M), .HBURST_M(HBURST_M), .HADDR_M(HADDR_M), .HWRITE_M(HWRITE_M),
        .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M), .HREADY(HREADY),
        .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic drive(input logic m, input logic [1:0] tr, input logic [2:0] bu,
                         input logic [31:0] ad, input logic wr, input logic [31:0] wd);
        if (m == 1'b0) begin
            HTRANS_M[1:0] = tr; HBURST_M[2:0] = bu; HADDR_M[31:0] = ad;
            HWRITE_M[0] = wr;   HSIZE_M[2:0] = 3'b010; HWDATA_M[31:0] = wd;
        end else begin
            HTRANS_M[3:2] = tr; HBURST_M[5:3] = bu; HADDR_M[63:32] = ad;
            HWRITE_M[1] = wr;   HSIZE_M[5:3] = 3'b010; HWDATA_M[63:32] = wd;
        end
    endtask

    task automatic do_reset();
        HBUSREQ = '0; HLOCK = '0; HTRANS_M = '0; HBURST_M = '0; HADDR_M = '0;
        HWRITE_M = '0; HSIZE_M = '0; HWDATA_M = '0; HREADY = 1'b1;
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL reset_grant: got %b want 01", HGRANT); end
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL idle_grant: got %b want 01", HGRANT); end
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL idle_hmaster: got %b want 0", HMASTER); end
        checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL idle_mastlock: got %b want 0", HMASTLOCK); end
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_g;
        logic        exp_m;
        logic [31:0] exp_a;
        do_reset();
        HBUSREQ = 2'b11;
        drive(1'b0, NONSEQ, SINGLE, 32'h0000_0100, 1'b0, 32'h0);
        drive(1'b1, NONSEQ, SINGLE, 32'h0000_0200, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge HCLK); #1;
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_m = (k % 2 == 1) ? 1'b0 : 1'b1;
            exp_a = (k % 2 == 1) ? 32'h0000_0100 : 32'h0000_0200;
            checks++; if (HGRANT !== exp_g) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", k, HGRANT, exp_g); end
            checks++; if (HMASTER !== exp_m) begin errors++; $display("FAIL fair_hmaster[%0d]: got %b want %b", k, HMASTER, exp_m); end
            checks++; if (HADDR !== exp_a) begin errors++; $display("FAIL fair_haddr[%0d]: got %h want %h", k, HADDR, exp_a); end
        end
        checks++; if (HBURST !== SINGLE || HSIZE !== 3'b010 || HTRANS !== NONSEQ) begin
            errors++; $display("FAIL fair_ctrl_mux: got trans %b burst %b size %b want 10 000 010", HTRANS, HBURST, HSIZE);
        end
    endtask

    task automatic test_burst();
        do_reset();
        HBUSREQ = 2'b11;
        drive(1'b1, IDLE, SINGLE, 32'h0, 1'b1, 32'hBBBB_0000);
        drive(1'b0, NONSEQ, INCR4, 32'h0000_1000, 1'b1, 32'h0);
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL burst_hold_a: got %b want 01", HGRANT); end
        drive(1'b0, SEQ, INCR4, 32'h0000_1004, 1'b1, 32'hD000_0000);
        #1;
        checks++; if (HWDATA !== 32'hD000_0000) begin errors++; $display("FAIL burst_wdata0: got %h want d0000000", HWDATA); end
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL burst_hold_b: got %b want 01", HGRANT); end
        drive(1'b0, SEQ, INCR4, 32'h0000_1008, 1'b1, 32'hD000_0001);
        #1;
        checks++; if (HWDATA !== 32'hD000_0001) begin errors++; $display("FAIL burst_wdata1: got %h want d0000001", HWDATA); end
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL burst_hold_c: got %b want 01", HGRANT); end
        drive(1'b0, SEQ, INCR4, 32'h0000_100C, 1'b1, 32'hD000_0002);
        #1;
        checks++; if (HWDATA !== 32'hD000_0002) begin errors++; $display("FAIL burst_wdata2: got %h want d0000002", HWDATA); end
        checks++; if (HADDR !== 32'h0000_100C) begin errors++; $display("FAIL burst_addr3: got %h want 0000100c", HADDR); end
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL burst_switch: got %b want 10", HGRANT); end
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL burst_hmaster_lag: got %b want 0", HMASTER); end
        HBUSREQ = 2'b10;
        drive(1'b0, IDLE, SINGLE, 32'h0, 1'b1, 32'hD000_0003);
        #1;
        checks++; if (HWDATA !== 32'hD000_0003) begin errors++; $display("FAIL burst_wdata3: got %h want d0000003", HWDATA); end
        @(posedge HCLK); #1;
        checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL burst_handover: got %b want 1", HMASTER); end
        checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL burst_keep_m1: got %b want 10", HGRANT); end
    endtask

    task automatic test_wait_states();
        do_reset();
        HBUSREQ = 2'b10;
        drive(1'b0, IDLE, SINGLE, 32'h0, 1'b0, 32'h0BAD_0BAD);
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL wait_grant_m1: got %b want 10", HGRANT); end
        drive(1'b1, NONSEQ, SINGLE, 32'h0000_2000, 1'b1, 32'h0);
        @(posedge HCLK); #1;
        checks++; if (HADDR !== 32'h0000_2000 || HWRITE !== 1'b1) begin
            errors++; $display("FAIL wait_addr_phase: got addr %h write %b want 00002000 1", HADDR, HWRITE);
        end
        @(posedge HCLK); #1;
        drive(1'b1, IDLE, SINGLE, 32'h0, 1'b0, 32'hCAFE_0001);
        HBUSREQ = 2'b01;
        HREADY  = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #1;
            checks++; if (HWDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL wait_wdata[%0d]: got %h want cafe0001", w, HWDATA); end
            checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL wait_hmaster[%0d]: got %b want 1", w, HMASTER); end
            checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL wait_grant[%0d]: got %b want 10", w, HGRANT); end
            @(posedge HCLK);
        end
        #1 HREADY = 1'b1;
        #1;
        checks++; if (HWDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL wait_release_wdata: got %h want cafe0001", HWDATA); end
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL wait_regrant: got %b want 01", HGRANT); end
        checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL wait_regrant_lag: got %b want 1", HMASTER); end
    endtask

    task automatic test_lock();
        do_reset();
        HBUSREQ = 2'b10;
        HLOCK   = 2'b10;
        drive(1'b1, NONSEQ, SINGLE, 32'h0000_3000, 1'b1, 32'h0);
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL lock_grant: got %b want 10", HGRANT); end
        HBUSREQ = 2'b11;
        @(posedge HCLK); #1;
        checks++; if (HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lock_mastlock_on: got %b want 1", HMASTLOCK); end
        for (int t = 0; t < 5; t++) begin
            @(posedge HCLK); #1;
            checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL lock_hold_grant[%0d]: got %b want 10", t, HGRANT); end
            checks++; if (HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lock_hold_mastlock[%0d]: got %b want 1", t, HMASTLOCK); end
        end
        HLOCK   = 2'b00;
        HBUSREQ = 2'b01;
        drive(1'b1, IDLE, SINGLE, 32'h0, 1'b0, 32'h0);
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL lock_release: got %b want 01", HGRANT); end
        @(posedge HCLK); #1;
        checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL lock_mastlock_off: got %b want 0", HMASTLOCK); end
    endtask

    task automatic test_timeout();
        int  cnt;
        bit  got;
        do_reset();
        HBUSREQ = 2'b01;
        drive(1'b0, NONSEQ, INCR, 32'h0000_4000, 1'b0, 32'h0);
        @(posedge HCLK); #1;
        drive(1'b0, SEQ, INCR, 32'h0000_4004, 1'b0, 32'h0);
        HBUSREQ = 2'b11;
`ifdef AHB_ARB_TIMEOUT_EN
        got = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge HCLK); #1;
            if (HGRANT === 2'b10) begin got = 1'b1; cnt = k; end
        end
        checks++; if (!got || cnt > 9) begin errors++; $display("FAIL timeout_preempt: took %0d edges (0=never) want 1..9", cnt); end
`else
        got = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(posedge HCLK); #1;
            checks++;
            if (HGRANT !== 2'b01) begin
                errors++; got = 1'b1; cnt = k;
                $display("FAIL incr_keep[%0d]: got %b want 01", k, HGRANT);
            end
        end
        HBUSREQ = 2'b10;
        drive(1'b0, IDLE, SINGLE, 32'h0, 1'b0, 32'h0);
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL incr_drop_regrant: got %b want 10", HGRANT); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        HBUSREQ = 2'b10;
        HLOCK   = 2'b10;
        drive(1'b1, NONSEQ, SINGLE, 32'h0000_5000, 1'b1, 32'h0);
        repeat (2) @(posedge HCLK);
        #1;
        checks++; if (HMASTER !== 1'b1 || HMASTLOCK !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got hmaster %b lock %b want 1 1", HMASTER, HMASTLOCK);
        end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL midrst_grant: got %b want 01", HGRANT); end
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL midrst_hmaster: got %b want 0", HMASTER); end
        checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL midrst_mastlock: got %b want 0", HMASTLOCK); end
        HRESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_burst();
        test_wait_states();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
